// File: rtl/lut_sxx_chain.sv
// Cascaded SXX LUT slice: STAGES LUTs of INPUTS inputs each, where every
// stage after the first takes the previous stage's result as its address MSB.
// The configuration streams in MSB-first through a valid/ready beat port into
// a shadow register and is committed to the active table in a single edge, so
// the fabric keeps evaluating the old function for the whole load.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no load in progress; beats ignored, waiting for cfg_start
// S_LOAD   | accepting beats into the shadow; abort returns to idle
// S_COMMIT | one cycle; shadow copied to active on the exiting edge
module lut_sxx_chain #(
   parameter int INPUTS  = 4,
   parameter int STAGES  = 2,
   parameter int SHIFT_W = 8,
   parameter int REG_OUT = 0,
   localparam int MEM_SIZE = 2 ** INPUTS,
   localparam int ADDR_W   = INPUTS + (STAGES - 1) * (INPUTS - 1),
   localparam int CFG_W    = STAGES * MEM_SIZE,
   localparam int BEATS    = CFG_W / SHIFT_W
) (
   input  logic               i_cclk,
   input  logic               i_rst,
   input  logic [ADDR_W-1:0]  i_addr,
   output logic               o_out,
   input  logic               i_cfg_start,
   input  logic               i_cfg_abort,
   input  logic               i_cfg_valid,
   output logic               o_cfg_ready,
   input  logic [SHIFT_W-1:0] i_cfg_data,
   output logic               o_cfg_busy,
   output logic               o_cfg_done
);

   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [CNT_W-1:0] r_count;
   logic [CFG_W-1:0] r_shadow;
   logic [CFG_W-1:0] r_active;
   logic             r_done;
   logic             w_accept;
   logic             w_abort;
   logic [CFG_W-1:0] w_shadow_next;
   logic             w_chain;

   // State register.
   always_ff @(posedge i_cclk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state decode; abort outranks a beat arriving in the same cycle.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_abort      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_cfg_start) w_state_next = S_LOAD;
         end
         S_LOAD: begin
            if (i_cfg_abort) begin
               w_abort      = 1'b1;
               w_state_next = S_IDLE;
            end else if (i_cfg_valid) begin
               w_accept = 1'b1;
               if (r_count == LAST_BEAT) w_state_next = S_COMMIT;
            end
         end
         S_COMMIT: w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   assign o_cfg_ready = (r_state == S_LOAD);
   assign o_cfg_busy  = (r_state != S_IDLE);
   assign o_cfg_done  = r_done;

   // Shift the new beat in at the bottom so the first beat lands in the MSBs.
   always_comb begin
      logic [CFG_W+SHIFT_W-1:0] w_cat;
      w_cat         = {r_shadow, i_cfg_data};
      w_shadow_next = w_cat[CFG_W-1:0];
   end

   // Beat counter, shadow, active table and the commit pulse.
   always_ff @(posedge i_cclk or posedge i_rst) begin
      if (i_rst) begin
         r_count  <= '0;
         r_shadow <= '0;
         r_active <= '0;
         r_done   <= 1'b0;
      end else begin
         if (r_state == S_IDLE && i_cfg_start) r_count <= '0;
         else if (w_accept)                    r_count <= r_count + CNT_W'(1);

         if (w_abort)       r_shadow <= '0;
         else if (w_accept) r_shadow <= w_shadow_next;

         if (r_state == S_COMMIT) r_active <= r_shadow;

         r_done <= (r_state == S_COMMIT);
      end
   end

   // Stage 0 owns the top MEM_SIZE bits of the active table and the top
   // INPUTS address bits; each later stage consumes the next INPUTS-1 bits.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [INPUTS-1:0]   w_sa;
      logic [MEM_SIZE-1:0] w_mem;
      logic                w_out;
      if (k == 0) begin : g_first
         assign w_sa = i_addr[ADDR_W-1 -: INPUTS];
      end else begin : g_next
         assign w_sa = {g_stage[k-1].w_out,
                        i_addr[ADDR_W-1-INPUTS-(k-1)*(INPUTS-1) -: INPUTS-1]};
      end
      assign w_mem = r_active[(STAGES-1-k)*MEM_SIZE +: MEM_SIZE];
      assign w_out = w_mem[w_sa];
   end

   assign w_chain = g_stage[STAGES-1].w_out;

   if (REG_OUT != 0) begin : g_reg_out
      logic r_out;
      // Output register adds one cycle of latency from addr to out.
      always_ff @(posedge i_cclk or posedge i_rst) begin
         if (i_rst) r_out <= 1'b0;
         else       r_out <= w_chain;
      end
      assign o_out = r_out;
   end else begin : g_comb_out
      assign o_out = w_chain;
   end

endmodule
